// File: rtl/axi_lite_imem_responder.sv
// AXI-lite style instruction-memory responder.
// Accepts one read address at a time, waits LATENCY cycles, then presents a
// single 32-bit word (or an error for addresses outside the memory window)
// until the initiator takes it. A separate byte-masked write port preloads or
// patches the memory and may be used in any state.
module axi_lite_imem_responder #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2   // 0..15, counter is 4 bits wide
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        araddr_valid,
  output logic        araddr_ready,
  input  logic [31:0] araddr_bits_addr,
  output logic        raddr_valid,
  input  logic        raddr_ready,
  output logic [31:0] raddr_bits_data,
  output logic        raddr_bits_resp,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  // Byte span of the window, one bit wider so the compare cannot overflow.
  localparam logic [32:0] SPAN    = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_CNT = LATENCY[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  // Response load strobe and the address it decodes. With zero latency the
  // load happens on the handshake edge itself, before addr_q holds the address.
  logic        load_en;
  logic [31:0] load_addr;

  logic [31:0]           rd_off;
  logic                  rd_in_range;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic [31:0]           wr_off;
  logic                  wr_in_range;
  logic [DEPTH_LOG2-1:0] wr_idx;

  logic [31:0]           ram_word;

  // Address decode for the read side: offset from BASE with 32-bit wrap, so
  // addresses below BASE land far above the window and report an error.
  always_comb begin
    rd_off      = load_addr - BASE;
    rd_in_range = ({1'b0, rd_off} < SPAN);
    rd_idx      = rd_off[DEPTH_LOG2+1:2];
  end

  // Address decode for the write side; out-of-window writes are dropped.
  always_comb begin
    wr_off      = wr_addr - BASE;
    wr_in_range = ({1'b0, wr_off} < SPAN);
    wr_idx      = wr_off[DEPTH_LOG2+1:2];
  end

  // Next-state and handshake outputs for the single-outstanding read FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    err_d        = err_q;
    load_en      = 1'b0;
    load_addr    = addr_q;
    araddr_ready = 1'b0;
    raddr_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        araddr_ready = 1'b1;
        if (araddr_valid) begin
          addr_d = araddr_bits_addr;
          if (LATENCY == 0) begin
            load_en   = 1'b1;
            load_addr = araddr_bits_addr;
            state_d   = S_RESP;
          end else begin
            cnt_d   = LAT_CNT;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The last wait edge samples memory and enters RESP; <= guards
        // against a zero count ever stalling the FSM here.
        if (cnt_q <= 4'd1) begin
          load_en = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        raddr_valid = 1'b1;
        if (raddr_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_en) begin
      err_d = ~rd_in_range;
    end
  end

  // FSM state, wait counter, latched address and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Memory split into four byte lanes so each lane is a plain RAM with its own
  // write enable. Reads register only on load_en, which freezes the word for
  // the whole RESP phase; a same-edge write is not seen (read-before-write).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q;

    // Byte-lane write, independent of the read FSM.
    always_ff @(posedge clk) begin
      if (wr_en && wr_in_range && wr_mask[gi]) begin
        lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      end
    end

    // Registered lane read, captured on the edge that enters RESP.
    always_ff @(posedge clk) begin
      if (load_en) begin
        lane_q <= lane_mem[rd_idx];
      end
    end

    assign ram_word[gi*8 +: 8] = lane_q;
  end

  // Response outputs are zero outside RESP and for errored fetches, which also
  // gives the all-zero values straight out of reset.
  always_comb begin
    raddr_bits_data = ((state_q == S_RESP) && !err_q) ? ram_word : 32'd0;
    raddr_bits_resp = (state_q == S_RESP) && err_q;
  end

endmodule

// File: doc/axi_lite_imem_responder.md
Name: axi_lite_imem_responder

Overview:
- AXI-lite read-channel responder that serves instruction fetches issued by the npc core's AXI read initiator (araddr/raddr channels).
- Holds a word-addressed memory array with a byte-masked preload/store write port.
- Returns one 32-bit word per accepted address after a programmable wait, with an error response for out-of-range addresses.
- Instantiated beside npc in the simulation top.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words.
- LATENCY, 2, wait cycles between address acceptance and data valid (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- araddr_valid  in  1  initiator presents a read address.
- araddr_ready  out  1  responder accepts the address.
- araddr_bits_addr  in  32  byte address.
- raddr_valid  out  1  read data valid.
- raddr_ready  in  1  initiator accepts the data.
- raddr_bits_data  out  32  read word.
- raddr_bits_resp  out  1  0 = OKAY, 1 = error (out of range).
- wr_en  in  1  memory write strobe.
- wr_addr  in  32  byte address of the write.
- wr_data  in  32  write word.
- wr_mask  in  4  byte enables, bit i enables byte i.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, araddr_ready=1, raddr_valid=0, raddr_bits_data=0, raddr_bits_resp=0, latency counter=0.
  - Memory contents are not reset.
  - Reset asserted mid-transaction drops the transaction; no response is produced after reset release.
- States:
  - IDLE: araddr_ready=1, raddr_valid=0. On a rising edge with araddr_valid&araddr_ready, latch the address. Go to WAIT with count=LATENCY, or go directly to RESP when LATENCY=0.
  - WAIT: araddr_ready=0, raddr_valid=0. Decrement count each edge. The edge where count==1 loads the response and moves to RESP.
  - RESP: araddr_ready=0, raddr_valid=1. Data and resp are held stable until raddr_ready is sampled high. On that handshake edge, go to IDLE.
- Latency and throughput:
  - Address handshake at edge T gives raddr_valid=1 starting in the cycle after edge T+LATENCY.
  - With LATENCY=0, raddr_valid rises in the cycle right after the address handshake.
  - One outstanding transaction only. araddr_ready is never high while a transaction is in WAIT or RESP. Back-to-back minimum is LATENCY+2 cycles per fetch.
- Address decode:
  - off = addr - BASE (32-bit wrap).
  - In range when off < 4<<DEPTH_LOG2. The word index is off[DEPTH_LOG2+1:2]; addr[1:0] is ignored and resp=0.
  - Out of range (including addr < BASE through wrap): data=0, resp=1, same latency.
- Response data:
  - The memory word is sampled on the edge that enters RESP.
  - A write to the same word on that same edge is not visible: the read sees old data.
  - Writes on earlier edges are visible.
  - Data is frozen while in RESP; later writes do not change raddr_bits_data.
- Write port:
  - Synchronous; on each edge with wr_en=1 and wr_addr in range, bytes with wr_mask[i]=1 update.
  - Out-of-range writes are ignored silently.
  - The write port is independent of the read FSM and legal in any state.
- raddr_valid must never deassert without a handshake. The responder ignores araddr_valid outside IDLE.

Test Plan:
- Preload 0x8000_0000=0x00000513 with LATENCY=2. Handshake at edge T with raddr_ready=1 held -> raddr_valid high the cycle after edge T+2, data=0x00000513, resp=0; IDLE one cycle later.
- Same fetch with raddr_ready low for 5 cycles -> raddr_valid stays 1, data stable, araddr_ready=0 throughout; completes on the first ready edge.
- Fetch 0x7FFF_FFFC and 0x8000_1000 (DEPTH_LOG2=10) -> each returns data=0, resp=1 with normal latency.
- Word 0x8000_0004=0x11223344; write wr_mask=4'b0010, wr_data=0xAABBCCDD, one edge before RESP entry -> read 0x1122CC44. Same write on the RESP-entry edge -> read 0x11223344, and a subsequent read returns 0x1122CC44.
- Fetch addr 0x8000_0007 -> returns the word at 0x8000_0004, resp=0.
- Assert rst during WAIT -> outputs at reset values immediately (asynchronous); after release, araddr_ready=1 and no raddr_valid pulse appears. Repeat with LATENCY=0 -> valid one cycle after handshake.
